mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, giving memory read latency in cycles (legal range 1..15).
REQ-002 The block SHALL have parameter AW, default 32, giving address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 The block SHALL have ports req0 and req1, input, 1: access request from CPU (0) and loader/debug (1).
REQ-006 The block SHALL have ports we0 and we1, input, 1: 1 = write, 0 = read, for each requester.
REQ-007 The block SHALL have ports addr0 and addr1, input, AW, and wdata0 and wdata1, input, 32: request address and write data.
REQ-008 The block SHALL have ports ack0 and ack1, output, 1: one-cycle completion pulse per requester.
REQ-009 The block SHALL have ports rdata0 and rdata1, output, 32: read data, valid in the ack cycle.
REQ-010 The block SHALL have ports mem_en, output, 1; mem_we, output, 1; mem_addr, output, AW; mem_wdata, output, 32.
REQ-011 The block SHALL have port mem_rdata, input, 32: memory read data.
REQ-012 The block SHALL have ports busy, output, 1, and grant, output, 2: one-hot current owner, 00 when idle.

Function
REQ-013 The block SHALL implement states IDLE, ISSUE, WAIT and DONE.
REQ-014 IDLE SHALL sample req0/req1 each cycle; if any is high, it SHALL latch winner id, we, addr and wdata, then go to ISSUE.
REQ-015 Arbitration SHALL be round-robin: with both requests high, the winner is the requester not granted last; a single request wins unconditionally.
REQ-016 The last-granted pointer SHALL update only on entry to ISSUE.
REQ-017 In ISSUE (exactly one cycle), mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL drive the latched values; then the state SHALL go to WAIT with counter = LATENCY-1.
REQ-018 mem_en SHALL be 0 in every state other than ISSUE; mem_addr/mem_wdata SHALL hold the latched values outside ISSUE.
REQ-019 WAIT SHALL decrement the counter each cycle; at counter = 0 the block SHALL register mem_rdata (memory presents it during the cycle LATENCY after ISSUE) and go to DONE.
REQ-020 With LATENCY = 1, WAIT SHALL last one cycle.
REQ-021 In DONE (one cycle), ack of the winner SHALL be 1 and its rdata SHALL hold the captured word; the next state SHALL be IDLE.
REQ-022 The ack/rdata behaviour of REQ-021 SHALL be identical for writes; rdata content on writes is don't-care.
REQ-023 Request-to-ack latency SHALL be LATENCY+2 cycles after the IDLE sampling cycle (default: ack 4 cycles after acceptance).
REQ-024 A requester SHALL hold req/we/addr/wdata until its ack; req high in the cycle after ack SHALL be treated as a new request.
REQ-025 Deassertion of req after acceptance SHALL be ignored, and the transaction SHALL complete with ack.
REQ-026 Deassertion of req before acceptance SHALL withdraw the request.
REQ-027 busy SHALL be 1 in ISSUE, WAIT and DONE; grant SHALL show the winner in those states.
REQ-028 A non-winning ack and rdata SHALL remain 0.
REQ-029 A request arriving while not IDLE SHALL wait; it SHALL not be lost, and it SHALL not preempt.

Reset
REQ-030 On reset assertion, at any time, the block SHALL asynchronously go to IDLE and clear all outputs to 0, the counter to 0 and the latched fields to 0.
REQ-031 On reset, the block SHALL set last-granted = 1, so requester 0 wins the first tie.
REQ-032 A transaction interrupted by reset SHALL never be acked.
REQ-033 The first request SHALL be sampled in the first clock edge after reset deasserts.

Verification
REQ-034 Single read: req0=1, we0=0, addr0=0x40, memory returns 0xDEADBEEF -> mem_en one cycle with mem_addr=0x40; ack0 plus rdata0=0xDEADBEEF 4 cycles after acceptance; ack1 stays 0.
REQ-035 Tie after reset: req0 and req1 both high continuously -> grants alternate 0,1,0,1; each ack spaced 5 cycles apart; no back-to-back grants to the same requester.
REQ-036 Write: req1=1, we1=1, addr1=0x10, wdata1=0x12345678 -> ISSUE cycle shows mem_we=1, mem_addr=0x10, mem_wdata=0x12345678; ack1 follows 3 cycles after ISSUE.
REQ-037 Reset mid-WAIT: assert reset during WAIT of a req0 read -> all outputs 0 immediately, no ack0 ever; after release, held req0 is re-accepted and completes normally.
REQ-038 LATENCY=1 instance: a read issued at cycle C is acked at C+2 with mem_rdata sampled in cycle C+1.
REQ-039 Late contender: req1 rises while req0 is in WAIT -> req0 acks undisturbed; req1 is accepted in the following IDLE cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-requester round-robin arbiter for a single-port memory
//               with a fixed read latency. One transaction at a time walks
//               IDLE -> ISSUE -> WAIT -> DONE; the winner gets a one-cycle
//               ack with its read data.
// Ports       : clk, reset          - clock, async active-high reset
//               req/we/addr/wdata0  - requester 0 (CPU)
//               req/we/addr/wdata1  - requester 1 (loader/debug)
//               ack0/1, rdata0/1    - completion pulse and read data
//               mem_en/we/addr/wdata, mem_rdata - memory-side port
//               busy, grant         - activity flag and one-hot owner
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int LATENCY = 2,
   parameter int AW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [31:0]   wdata0,
   input  logic [31:0]   wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [31:0]   rdata0,
   output logic [31:0]   rdata1,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic          busy,
   output logic [1:0]    grant
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // WAIT runs LATENCY cycles, counting LATENCY-1 down to 0.
   localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          owner_q, owner_d;   // requester id of the active transaction
   logic          last_q, last_d;     // requester granted most recently
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          w_win;

   // On a tie the requester that did not win last time takes the port.
   assign w_win = (req0 && req1) ? ~last_q : req1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               owner_d = w_win;
               last_d  = w_win;
               we_d    = w_win ? we1    : we0;
               addr_d  = w_win ? addr1  : addr0;
               wdata_d = w_win ? wdata1 : wdata0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = c_cnt_init;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               // Memory presents the word in this cycle.
               rdata_d = mem_rdata;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;   // requester 0 wins the first tie
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs decode the registered state only, so an asynchronous reset
   // clears them immediately.
   assign mem_en    = (state_q == ST_ISSUE);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state_q != ST_IDLE);
   assign grant     = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign ack0      = (state_q == ST_DONE) && !owner_q;
   assign ack1      = (state_q == ST_DONE) &&  owner_q;
   assign rdata0    = ack0 ? rdata_q : 32'd0;
   assign rdata1    = ack1 ? rdata_q : 32'd0;

endmodule
`default_nettype wire
